mem_instr_arb: RTL and testbench
================================

MEM_INSTR_ARB -- requirements
Module: mem_instr_arb

Interface
REQ-001 Parameter: MEM_BYTES, 256, byte capacity of the shared instruction memory.
REQ-002 Parameter: LOAD_PRIO, 0, 1 gives the loader port fixed priority; 0 gives round-robin.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous and active-high.
REQ-005 Port: f_req  in  1  fetch port request (read only).
REQ-006 Port: f_addr  in  32  fetch byte address.
REQ-007 Port: f_gnt  out  1  fetch request accepted this cycle.
REQ-008 Port: f_rvalid  out  1  fetch response valid.
REQ-009 Port: f_rdata  out  32  fetch read word.
REQ-010 Port: f_err  out  1  fetch response error (misaligned or out of range).
REQ-011 Port: l_req  in  1  loader port request.
REQ-012 Port: l_we  in  1  loader write enable (1 write, 0 read).
REQ-013 Port: l_addr  in  32  loader byte address.
REQ-014 Port: l_wdata  in  32  loader write word.
REQ-015 Port: l_gnt / l_rvalid / l_err  out  1 each  loader accept, response valid, error.
REQ-016 Port: l_rdata  out  32  loader read word.
REQ-017 Port: m_addr  out  32  memory byte address.
REQ-018 Port: m_we  out  1  memory write strobe.
REQ-019 Port: m_wdata  out  32  memory write word.
REQ-020 Port: m_rdata  in  32  memory read word, combinational from m_addr.

Function
REQ-021 FSM states IDLE, ACC_F, ACC_L; IDLE->ACC_F or ACC_L on grant; ACC_x->IDLE after one cycle, or directly to the next ACC state if a request is pending (back-to-back, one access per cycle).
REQ-022 Grant is combinational from req and FSM state: at most one of f_gnt, l_gnt high per cycle; gnt only when req is high.
REQ-023 Round-robin (LOAD_PRIO=0): on simultaneous requests grant the port not granted last; last-grant pointer resets to loader, so fetch wins the first tie.
REQ-024 LOAD_PRIO=1: loader always wins a tie; fetch granted only when l_req low.
REQ-025 In the grant cycle m_addr = granted address, m_wdata = l_wdata, m_we = l_we & l_gnt & ~error; otherwise m_addr holds the last value, m_we = 0.
REQ-026 Error: addr[1:0] != 0 or addr > MEM_BYTES-4; an erroneous access never asserts m_we and returns rdata 0.
REQ-027 Latency: response exactly one cycle after grant; rvalid pulses one cycle on the granted port with rdata = m_rdata registered in the grant cycle (0 for writes) and err registered.
REQ-028 Non-granted port rvalid/err remain 0; rdata holds its last value.
REQ-029 Requester holds req/addr/wdata stable until gnt; arbiter does not buffer ungranted requests.
REQ-030 Write then read of the same address on consecutive grants returns the written word.

Reset
REQ-031 While rst high: FSM = IDLE, gnt/rvalid/err = 0, m_we = 0, m_addr = 0, m_wdata = 0, rdata = 0, last-grant = loader.
REQ-032 rst asserted mid-access cancels the pending response; no rvalid after rst release without a new grant.
REQ-033 First grant possible in the first rising edge after rst deasserts.

Verification
REQ-034 Fetch only, f_addr=0x04, m_rdata=0x00100093 -> f_gnt same cycle, f_rvalid=1, f_rdata=0x00100093, f_err=0 next cycle.
REQ-035 Both req every cycle, LOAD_PRIO=0 -> grants alternate F,L,F,L; no cycle with both gnt high.
REQ-036 LOAD_PRIO=1, both req held 3 cycles -> l_gnt 3 cycles, f_gnt 0.
REQ-037 Loader write addr=0x08 data=0xDEADBEEF, then fetch 0x08 -> m_we one cycle, f_rdata=0xDEADBEEF.
REQ-038 Loader write addr=0x06 and fetch addr=0x100 (MEM_BYTES=256) -> m_we=0, l_err=1, f_err=1, rdata=0.
REQ-039 rst pulse in cycle after grant -> no rvalid, all outputs at reset values.

Source files
------------

// File: rtl/mem_instr_arb.sv
// mem_instr_arb: arbiter between an instruction-fetch port and a loader port
// that share one single-ported, word-wide instruction memory.
//
// Each cycle at most one request is granted (combinationally). The granted
// address and write data are driven onto the memory bus in that same cycle.
// The response (rvalid, rdata, err) is presented on the granted port exactly
// one cycle later.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   f_req, f_addr     fetch request (read only) and byte address
//   f_gnt             fetch request accepted this cycle
//   f_rvalid/f_rdata/f_err   fetch response, one cycle after f_gnt
//   l_req, l_we, l_addr, l_wdata   loader request (read or write)
//   l_gnt             loader request accepted this cycle
//   l_rvalid/l_rdata/l_err   loader response, one cycle after l_gnt
//   m_addr, m_we, m_wdata    memory bus; m_rdata returns combinationally
//   dbg_state         current FSM state (IDLE=0, ACC_F=1, ACC_L=2)
//
// Handshake: a requester raises req with addr/wdata stable and holds them
// until it sees gnt high in the same cycle; the arbiter does not queue
// ungranted requests. A grant always produces a single-cycle rvalid pulse on
// the same port in the following cycle, unless rst intervenes.

module mem_instr_arb #(
  parameter int MEM_BYTES = 256,
  parameter bit LOAD_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        l_err,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_F = 2'd1,
    ACC_L = 2'd2
  } state_e;

  // Highest byte address at which a full word still fits in memory.
  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

  state_e      state_q, state_d;
  logic        last_l_q, last_l_d;   // 1 = loader was granted most recently
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] l_rdata_q, l_rdata_d;
  logic        f_err_q, f_err_d;
  logic        l_err_q, l_err_d;

  logic        f_bad;
  logic        l_bad;

  assign f_bad = (f_addr[1:0] != 2'b00) || (f_addr > ADDR_MAX);
  assign l_bad = (l_addr[1:0] != 2'b00) || (l_addr > ADDR_MAX);

  // Grant: gated by rst so nothing is accepted while reset is held. On a tie
  // the loader wins if it has fixed priority, or if fetch was served last.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (f_req && l_req) begin
        if (LOAD_PRIO || !last_l_q) begin
          l_gnt = 1'b1;
        end else begin
          f_gnt = 1'b1;
        end
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
    end
  end

  // Next state: every state may accept a new grant, so the ACC states chain
  // back-to-back; with no grant the FSM returns to IDLE.
  always_comb begin
    state_d = IDLE;
    if (f_gnt) begin
      state_d = ACC_F;
    end else if (l_gnt) begin
      state_d = ACC_L;
    end
  end

  // Memory bus and response capture.
  always_comb begin
    last_l_d  = last_l_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    f_rdata_d = f_rdata_q;
    l_rdata_d = l_rdata_q;
    f_err_d   = f_gnt & f_bad;
    l_err_d   = l_gnt & l_bad;

    if (f_gnt) begin
      last_l_d  = 1'b0;
      m_addr_d  = f_addr;
      f_rdata_d = f_bad ? 32'h0 : m_rdata;
    end else if (l_gnt) begin
      last_l_d  = 1'b1;
      m_addr_d  = l_addr;
      m_wdata_d = l_wdata;
      // Writes and erroneous reads return zero.
      l_rdata_d = (l_bad || l_we) ? 32'h0 : m_rdata;
    end
  end

  assign m_addr  = m_addr_d;
  assign m_wdata = m_wdata_d;
  assign m_we    = l_gnt & l_we & ~l_bad;

  // Response outputs decoded from state; err flags are only ever set for the
  // granted port so they are zero on the other one.
  always_comb begin
    f_rvalid  = (state_q == ACC_F);
    l_rvalid  = (state_q == ACC_L);
    f_err     = f_err_q;
    l_err     = l_err_q;
    f_rdata   = f_rdata_q;
    l_rdata   = l_rdata_q;
    dbg_state = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_l_q  <= 1'b1;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      f_rdata_q <= 32'h0;
      l_rdata_q <= 32'h0;
      f_err_q   <= 1'b0;
      l_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_l_q  <= last_l_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      f_rdata_q <= f_rdata_d;
      l_rdata_q <= l_rdata_d;
      f_err_q   <= f_err_d;
      l_err_q   <= l_err_d;
    end
  end

endmodule

// File: tb/tb_mem_instr_arb.sv
// Testbench for mem_instr_arb: a round-robin instance (u_rr) and a
// loader-priority instance (u_lp) share all inputs; each has its own memory.

module tb_mem_instr_arb;

  logic        clk;
  logic        rst;
  logic        f_req, l_req, l_we;
  logic [31:0] f_addr, l_addr, l_wdata;

  logic        f_gnt0, f_rvalid0, f_err0, l_gnt0, l_rvalid0, l_err0, m_we0;
  logic [31:0] f_rdata0, l_rdata0, m_addr0, m_wdata0, m_rdata0;
  logic [1:0]  dbg0;
  logic        f_gnt1, f_rvalid1, f_err1, l_gnt1, l_rvalid1, l_err1, m_we1;
  logic [31:0] f_rdata1, l_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic [1:0]  dbg1;

  logic [31:0] mem0 [0:63];
  logic [31:0] mem1 [0:63];

  int n_checks;
  int n_errors;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_instr_arb #(.MEM_BYTES(256), .LOAD_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt0), .f_rvalid(f_rvalid0),
    .f_rdata(f_rdata0), .f_err(f_err0),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt0), .l_rvalid(l_rvalid0), .l_rdata(l_rdata0), .l_err(l_err0),
    .m_addr(m_addr0), .m_we(m_we0), .m_wdata(m_wdata0), .m_rdata(m_rdata0),
    .dbg_state(dbg0)
  );

  mem_instr_arb #(.MEM_BYTES(256), .LOAD_PRIO(1'b1)) u_lp (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt1), .f_rvalid(f_rvalid1),
    .f_rdata(f_rdata1), .f_err(f_err1),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt1), .l_rvalid(l_rvalid1), .l_rdata(l_rdata1), .l_err(l_err1),
    .m_addr(m_addr1), .m_we(m_we1), .m_wdata(m_wdata1), .m_rdata(m_rdata1),
    .dbg_state(dbg1)
  );

  // Memory models: combinational read, clocked write, preloaded during reset.
  assign m_rdata0 = mem0[m_addr0[7:2]];
  assign m_rdata1 = mem1[m_addr1[7:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mem0[i] <= 32'h0;
        mem1[i] <= 32'h0;
      end
      mem0[1] <= 32'h0010_0093;
      mem1[1] <= 32'h0010_0093;
      mem0[3] <= 32'h1234_5678;
      mem1[3] <= 32'h1234_5678;
    end else begin
      if (m_we0) mem0[m_addr0[7:2]] <= m_wdata0;
      if (m_we1) mem1[m_addr1[7:2]] <= m_wdata1;
    end
  end

  // driver tasks: inputs change 1 time unit after posedge, comb outputs are
  // sampled at the following negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    #4;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
    f_addr = 32'h0; l_addr = 32'h0; l_wdata = 32'h0;

    // Reset values, with a request present that must not be granted.
    tick(); tick();
    f_req = 1'b1; f_addr = 32'h4; l_req = 1'b1; l_addr = 32'h8;
    #1;
    check("rst_f_gnt", {31'h0, f_gnt0}, 32'h0);
    check("rst_l_gnt", {31'h0, l_gnt0}, 32'h0);
    check("rst_m_addr", m_addr0, 32'h0);
    check("rst_m_we", {31'h0, m_we0}, 32'h0);
    check("rst_m_wdata", m_wdata0, 32'h0);
    check("rst_f_rvalid", {31'h0, f_rvalid0}, 32'h0);
    check("rst_f_rdata", f_rdata0, 32'h0);
    check("rst_state", {30'h0, dbg0}, 32'h0);
    f_req = 1'b0; l_req = 1'b0;
    l_addr = 32'h0;

    // Fetch of 0x04 granted in the first cycle after reset release.
    rst = 1'b0;
    f_req = 1'b1; f_addr = 32'h4;
    half();
    check("f04_gnt", {31'h0, f_gnt0}, 32'h1);
    check("f04_l_gnt", {31'h0, l_gnt0}, 32'h0);
    check("f04_m_addr", m_addr0, 32'h4);
    check("f04_m_we", {31'h0, m_we0}, 32'h0);
    tick();
    f_req = 1'b0;
    check("f04_rvalid", {31'h0, f_rvalid0}, 32'h1);
    check("f04_rdata", f_rdata0, 32'h0010_0093);
    check("f04_err", {31'h0, f_err0}, 32'h0);
    check("f04_l_rvalid", {31'h0, l_rvalid0}, 32'h0);
    check("f04_state", {30'h0, dbg0}, 32'h1);
    tick();
    check("idle_rvalid", {31'h0, f_rvalid0}, 32'h0);
    check("idle_m_addr_hold", m_addr0, 32'h4);
    check("idle_rdata_hold", f_rdata0, 32'h0010_0093);

    // Loader write 0x08 = DEADBEEF, then fetch 0x08.
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h8; l_wdata = 32'hDEAD_BEEF;
    half();
    check("wr_l_gnt", {31'h0, l_gnt0}, 32'h1);
    check("wr_m_we", {31'h0, m_we0}, 32'h1);
    check("wr_m_addr", m_addr0, 32'h8);
    check("wr_m_wdata", m_wdata0, 32'hDEAD_BEEF);
    tick();
    l_req = 1'b0; l_we = 1'b0;
    f_req = 1'b1; f_addr = 32'h8;
    check("wr_l_rvalid", {31'h0, l_rvalid0}, 32'h1);
    check("wr_l_rdata", l_rdata0, 32'h0);
    check("wr_l_err", {31'h0, l_err0}, 32'h0);
    half();
    check("rd8_m_we", {31'h0, m_we0}, 32'h0);
    check("rd8_f_gnt", {31'h0, f_gnt0}, 32'h1);
    tick();
    f_req = 1'b0;
    check("rd8_rvalid", {31'h0, f_rvalid0}, 32'h1);
    check("rd8_rdata", f_rdata0, 32'hDEAD_BEEF);
    check("rd8_l_rvalid", {31'h0, l_rvalid0}, 32'h0);

    // Misaligned loader write and out-of-range fetch, requested together.
    // Fetch was served last, so the round-robin instance picks the loader.
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h6; l_wdata = 32'hCAFE_F00D;
    f_req = 1'b1; f_addr = 32'h100;
    half();
    check("err_l_gnt", {31'h0, l_gnt0}, 32'h1);
    check("err_f_gnt", {31'h0, f_gnt0}, 32'h0);
    check("err_m_we", {31'h0, m_we0}, 32'h0);
    check("err_lp_m_we", {31'h0, m_we1}, 32'h0);
    tick();
    l_req = 1'b0; l_we = 1'b0;
    check("err_l_rvalid", {31'h0, l_rvalid0}, 32'h1);
    check("err_l_err", {31'h0, l_err0}, 32'h1);
    check("err_l_rdata", l_rdata0, 32'h0);
    check("err_f_err_idle", {31'h0, f_err0}, 32'h0);
    half();
    check("err_f_gnt2", {31'h0, f_gnt0}, 32'h1);
    check("err_m_addr", m_addr0, 32'h100);
    tick();
    f_req = 1'b0;
    check("err_f_rvalid", {31'h0, f_rvalid0}, 32'h1);
    check("err_f_err", {31'h0, f_err0}, 32'h1);
    check("err_f_rdata", f_rdata0, 32'h0);
    check("err_l_err_clr", {31'h0, l_err0}, 32'h0);

    // Reset pulse right after a grant cancels the response.
    f_req = 1'b1; f_addr = 32'h4;
    half();
    check("rc_f_gnt", {31'h0, f_gnt0}, 32'h1);
    rst = 1'b1; f_req = 1'b0;
    #1;
    check("rc_gnt_in_rst", {31'h0, f_gnt0}, 32'h0);
    check("rc_m_addr", m_addr0, 32'h0);
    tick();
    check("rc_f_rvalid", {31'h0, f_rvalid0}, 32'h0);
    check("rc_f_rdata", f_rdata0, 32'h0);
    check("rc_f_err", {31'h0, f_err0}, 32'h0);
    check("rc_m_wdata", m_wdata0, 32'h0);
    rst = 1'b0;
    tick();
    check("rc_post_rvalid", {31'h0, f_rvalid0}, 32'h0);
    check("rc_post_state", {30'h0, dbg0}, 32'h0);

    // Both ports request every cycle: round-robin alternates F,L,F,L starting
    // with fetch after reset; loader-priority instance grants loader only.
    f_req = 1'b1; f_addr = 32'h0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'hC;
    for (int i = 0; i < 4; i++) begin
      half();
      check("rr_f_gnt", {31'h0, f_gnt0}, (i % 2 == 0) ? 32'h1 : 32'h0);
      check("rr_l_gnt", {31'h0, l_gnt0}, (i % 2 == 0) ? 32'h0 : 32'h1);
      check("rr_both", {31'h0, f_gnt0 & l_gnt0}, 32'h0);
      check("lp_l_gnt", {31'h0, l_gnt1}, 32'h1);
      check("lp_f_gnt", {31'h0, f_gnt1}, 32'h0);
      tick();
      if (i % 2 == 0) begin
        check("rr_f_rvalid", {31'h0, f_rvalid0}, 32'h1);
        check("rr_f_rdata", f_rdata0, 32'h0);
      end else begin
        check("rr_l_rvalid", {31'h0, l_rvalid0}, 32'h1);
        check("rr_l_rdata", l_rdata0, 32'h1234_5678);
      end
      check("lp_l_rvalid", {31'h0, l_rvalid1}, 32'h1);
    end
    f_req = 1'b0; l_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
